// File: rtl/fpu_uart_pkg.sv
// Shared constants and RX FSM state encoding for the FPU UART command-frame receiver.
package fpu_uart_pkg;

    localparam int FRAME_BYTES = 9;
    localparam int OPC_IDX     = 0;
    localparam int OPA_IDX     = 1;
    localparam int OPB_IDX     = 5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop line synchroniser plus bit-timing FSM.
// CLKS_PER_BIT must be at least 4 so the start-bit mid-sample lands inside the bit.
module uart_rx_byte
    import fpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       r_Rx_Serial,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       err_frame,
    output rx_state_e  state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic            sync1_q, rx_s_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      data_q, data_d;
    logic            byte_valid_q, byte_valid_d;
    logic            err_frame_q, err_frame_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        data_d       = data_q;
        byte_valid_d = 1'b0;
        err_frame_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (!rx_s_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // Mid-bit re-sample rejects glitches shorter than half a bit.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d         = '0;
                    data_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) state_d = RX_STOP;
                    else               idx_d   = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    byte_valid_d = rx_s_q;
                    err_frame_d  = !rx_s_q;
                    state_d      = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            byte_valid_q <= 1'b0;
            err_frame_q  <= 1'b0;
        end else begin
            sync1_q      <= r_Rx_Serial;
            rx_s_q       <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            byte_valid_q <= byte_valid_d;
            err_frame_q  <= err_frame_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = data_q;
    assign err_frame  = err_frame_q;
    assign state      = state_q;

endmodule

// File: rtl/fpu_uart_rx_frame.sv
// Assembles 9-byte UART command frames (opcode, opA, opB) and hands them to the FPU.
// Handshake: out_valid holds with stable out_* until a cycle with out_valid && out_ready.
module fpu_uart_rx_frame
    import fpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        r_Rx_Serial,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_opcode,
    output logic [31:0] out_opa,
    output logic [31:0] out_opb,
    output logic        err_frame,
    output logic        err_timeout,
    output logic        err_overrun
);

    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW       = $clog2(TO_LIMIT);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_LIMIT - 1);
    localparam logic [3:0]    LAST_SLOT = 4'(FRAME_BYTES - 1);

    logic       byte_valid, rx_err_frame;
    logic [7:0] byte_data;
    rx_state_e  rx_state;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk         (clk),
        .rst_l       (rst_l),
        .r_Rx_Serial (r_Rx_Serial),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .err_frame   (rx_err_frame),
        .state       (rx_state)
    );

    logic [FRAME_BYTES-2:0][7:0] shadow_q, shadow_d;
    logic [3:0]    byte_cnt_q, byte_cnt_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_opcode_q, out_opcode_d;
    logic [31:0]   out_opa_q, out_opa_d;
    logic [31:0]   out_opb_q, out_opb_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_overrun_q, err_overrun_d;

    always_comb begin
        shadow_d      = shadow_q;
        byte_cnt_d    = byte_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        out_valid_d   = out_valid_q;
        out_opcode_d  = out_opcode_q;
        out_opa_d     = out_opa_q;
        out_opb_d     = out_opb_q;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (byte_valid) begin
            idle_cnt_d = '0;
            if (byte_cnt_q == LAST_SLOT) begin
                byte_cnt_d = '0;
                // A frame may load in the same cycle the previous one is taken.
                if (!out_valid_q || out_ready) begin
                    out_valid_d  = 1'b1;
                    out_opcode_d = shadow_q[OPC_IDX];
                    out_opa_d    = {shadow_q[OPA_IDX+3], shadow_q[OPA_IDX+2],
                                    shadow_q[OPA_IDX+1], shadow_q[OPA_IDX]};
                    out_opb_d    = {byte_data, shadow_q[OPB_IDX+2],
                                    shadow_q[OPB_IDX+1], shadow_q[OPB_IDX]};
                end else begin
                    err_overrun_d = 1'b1;
                end
            end else begin
                shadow_d[byte_cnt_q[2:0]] = byte_data;
                byte_cnt_d = byte_cnt_q + 1'b1;
            end
        end else if (rx_err_frame) begin
            byte_cnt_d = '0;
            idle_cnt_d = '0;
        end else if (byte_cnt_q == 4'd0) begin
            idle_cnt_d = '0;
        end else if (rx_state == RX_IDLE) begin
            if (idle_cnt_q == TO_LAST) begin
                byte_cnt_d    = '0;
                idle_cnt_d    = '0;
                err_timeout_d = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            shadow_q      <= '0;
            byte_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            out_valid_q   <= 1'b0;
            out_opcode_q  <= '0;
            out_opa_q     <= '0;
            out_opb_q     <= '0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            byte_cnt_q    <= byte_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            out_valid_q   <= out_valid_d;
            out_opcode_q  <= out_opcode_d;
            out_opa_q     <= out_opa_d;
            out_opb_q     <= out_opb_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_opcode  = out_opcode_q;
    assign out_opa     = out_opa_q;
    assign out_opb     = out_opb_q;
    assign err_frame   = rx_err_frame;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;

endmodule
